// File: rtl/mdu_div_seq.sv
// Sequential restoring divider for the RV64M divide group (DIV/DIVU/REM/REMU and W forms).
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at launch.
module mdu_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_w_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] rem_q, quot_q, dvsr_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q_q, neg_r_q, sel_rem_q, is_w_q;

  function automatic logic signed [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{HALF{x[HALF-1]}}, x[HALF-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  logic                   is_signed, accept, a_neg, b_neg, div_zero, ovf;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]        a_mag, b_mag, a_res, ovf_min, spec_res;
  logic [XLEN:0]          shifted, diff;
  logic [XLEN-1:0]        rem_d, quot_d, fix_raw, fix_res;

  // Launch-side operand prep and special-case detection
  always_comb begin
    is_signed = ~funct3_i[0];
    accept    = start_i & funct3_i[2] & ~flush_i &
                ((state_q == S_IDLE) || (state_q == S_DONE));
    if (is_w_i) begin
      a_s = is_signed ? sext_w(rs1_i) : {{HALF{1'b0}}, rs1_i[HALF-1:0]};
      b_s = is_signed ? sext_w(rs2_i) : {{HALF{1'b0}}, rs2_i[HALF-1:0]};
      ovf_min = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      a_res = sext_w(rs1_i);
    end else begin
      a_s = rs1_i;
      b_s = rs2_i;
      ovf_min = {1'b1, {(XLEN-1){1'b0}}};
      a_res = rs1_i;
    end
    a_neg    = is_signed & a_s[XLEN-1];
    b_neg    = is_signed & b_s[XLEN-1];
    a_mag    = neg_if(a_s, a_neg);
    b_mag    = neg_if(b_s, b_neg);
    div_zero = (b_s == '0);
    ovf      = is_signed && (a_s == ovf_min) && (b_s == '1);
    if (div_zero) spec_res = funct3_i[1] ? a_res : '1;
    else          spec_res = funct3_i[1] ? '0 : a_res;
  end

  // Restoring step: remainder window gets the next dividend bit, keep if divisor fits
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quot_d  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    fix_raw = sel_rem_q ? neg_if(rem_q, neg_r_q) : neg_if(quot_q, neg_q_q);
    fix_res = is_w_q ? sext_w(fix_raw) : fix_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      is_w_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            rem_q     <= '0;
            // W ops left-align the 32-bit dividend so the same MSB feeds the shift
            quot_q    <= is_w_i ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            dvsr_q    <= b_mag;
            cnt_q     <= is_w_i ? CW'(HALF - 1) : CW'(XLEN - 1);
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            sel_rem_q <= funct3_i[1];
            is_w_q    <= is_w_i;
            if (div_zero || ovf) begin
              result_q <= spec_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fix_res;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: doc/mdu_div_seq.md
Name: mdu_div_seq

Overview:
- Multi-cycle sequencer and datapath for the RV64M divide group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the EXU ALU. The decode/control logic raises start_i for a divide instruction, and busy_o stalls the pipeline until done_o.
- Performs restoring division at one quotient bit per cycle, with a sign fix-up step.
- Resolves the RISC-V divide-by-zero and signed-overflow cases in a single cycle.

Parameters:
- XLEN, 64, operand/result width; W variants use XLEN/2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  launch a divide; sampled in IDLE or DONE only
- flush_i  input  1  kill the in-flight operation (pipeline flush)
- funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; others ignored (no launch)
- is_w_i  input  1  W variant (opcode[3] of the instruction)
- rs1_i  input  XLEN  dividend
- rs2_i  input  XLEN  divisor
- busy_o  output  1  high in CALC and FIXUP; pipeline stall request
- done_o  output  1  one-cycle pulse: result_o valid
- result_o  output  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (any state, including mid-operation): state=IDLE, busy_o=0, done_o=0, result_o=0, all internal registers cleared.
- States: IDLE, CALC, FIXUP, DONE.
- Launch: start_i=1 with a valid funct3_i in IDLE or DONE is an accepted start. Operands and opcode are latched at that edge.
  - start_i in CALC or FIXUP is ignored.
  - Invalid funct3_i is ignored.
- Operand prep:
  - W signed: low 32 bits, sign-extended to the internal width.
  - W unsigned: low 32 bits, zero-extended.
  - N = 32 for W ops, XLEN otherwise.
  - Signed ops: divide absolute values; record neg_q = sign(a)^sign(b) and neg_r = sign(a).
- Special cases, checked at launch. These go straight to DONE, with done_o in the cycle after the start cycle (latency 1):
  - divisor==0: quotient = all ones; remainder = dividend (W: sign-extended rs1_i[31:0]).
  - Signed overflow: dividend = most-negative N-bit value and divisor = -1. Quotient = dividend (W: sign-extended); remainder = 0.
- CALC:
  - Each cycle: shift the {rem,quot} pair left by 1, trial-subtract the divisor, keep the result if non-negative, and set the quotient LSB.
  - A counter runs from N-1 down to 0. CALC lasts exactly N cycles, then FIXUP.
- FIXUP (1 cycle):
  - Apply the neg_q/neg_r two's-complement negation to the quotient/remainder.
  - Select quotient (funct3_i[1]=0) or remainder (funct3_i[1]=1).
  - W ops: sign-extend bit 31 to XLEN, including DIVUW/REMUW.
  - Register result_o; next state DONE.
- Normal latency: done_o asserts N+2 cycles after the start cycle (66 for 64-bit ops, 34 for W ops).
- DONE:
  - done_o=1, busy_o=0 for exactly one cycle.
  - Next state IDLE, or CALC/DONE if start_i is accepted in this cycle (back-to-back supported).
- flush_i:
  - In any state, next state is IDLE and no done_o follows. result_o keeps its last value.
  - flush_i together with start_i: flush wins, no launch.
  - flush_i in DONE: the done_o pulse in that cycle still occurs; the next state is IDLE.
- busy_o is derived from the state register only (glitch-free); it is never asserted in IDLE or DONE.

Test Plan:
- DIVU rs1=100, rs2=7 -> busy_o for 65 cycles, done_o at start+66, result_o=14; REMU with the same operands -> result_o=2.
- DIV rs1=-7, rs2=2 -> result_o=-3 (0xFFFF_FFFF_FFFF_FFFD); REM -> -1; REM rs1=7, rs2=-2 -> 1.
- DIVU rs2=0, rs1=5 -> done_o at start+1, result_o=0xFFFF_FFFF_FFFF_FFFF; REMU -> 5. DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> result_o=0x8000_0000_0000_0000 at start+1; REM -> 0.
- DIVW rs1=0x0000_0000_8000_0000, rs2=-1 -> 0xFFFF_FFFF_8000_0000 at start+1. DIVUW rs1=0xFFFF_FFFF, rs2=1 -> 0xFFFF_FFFF_FFFF_FFFF at start+34.
- Flush at CALC cycle 10 -> IDLE next cycle, no done_o, result_o unchanged. start_i pulses during CALC are ignored. Back-to-back start in the DONE cycle -> second result correct.
- rst_n low mid-CALC -> all outputs 0 immediately (asynchronous). After release, a new DIVU 9/3 -> 3.
